// File: rtl/sensor_health_monitor.sv
// Sensor health monitor: classifies 3-bit sensor codes and runs a
// HEALTHY/SUSPECT/FAULTED/RECOVERING debounce FSM with a saturating fault counter.
module sensor_health_monitor #(
  parameter int FAULT_THRESH   = 3,
  parameter int RECOVER_THRESH = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [2:0]       sensor,
  output logic             class_valid,
  output logic [1:0]       class_code,
  output logic [1:0]       state,
  output logic             alarm,
  output logic [CNT_W-1:0] fault_count
);

  // Handshake: sample_valid qualifies sensor; there is no ready, every valid
  // sample is consumed on the rising edge where it is presented.
  typedef enum logic [1:0] {
    HEALTHY    = 2'b00,
    SUSPECT    = 2'b01,
    FAULTED    = 2'b10,
    RECOVERING = 2'b11
  } state_t;

  localparam logic [1:0]       CLS_NEUTRAL = 2'b00;
  localparam logic [1:0]       CLS_OK      = 2'b01;
  localparam logic [1:0]       CLS_FAULT   = 2'b10;
  localparam logic [3:0]       F_TH        = 4'(FAULT_THRESH);
  localparam logic [3:0]       R_TH        = 4'(RECOVER_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state_q, state_d;
  logic [3:0] consec_f_q, consec_f_d, consec_ok_q, consec_ok_d;
  logic [3:0] f_inc, ok_inc;
  logic       is_ok, is_fault;
  logic [1:0] cls;

  // OK outranks the 011 fault pattern, so 111 is OK.
  always_comb begin
    is_ok    = sensor[2];
    is_fault = !sensor[2] && (sensor[1:0] == 2'b11);
    cls      = is_ok ? CLS_OK : (is_fault ? CLS_FAULT : CLS_NEUTRAL);
  end

  assign f_inc  = consec_f_q + 4'd1;
  assign ok_inc = consec_ok_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    consec_f_d  = consec_f_q;
    consec_ok_d = consec_ok_q;
    if (sample_valid) begin
      case (state_q)
        HEALTHY: begin
          if (is_fault) begin
            if (FAULT_THRESH == 1) begin
              state_d     = FAULTED;
              consec_f_d  = 4'd0;
              consec_ok_d = 4'd0;
            end else begin
              state_d    = SUSPECT;
              consec_f_d = 4'd1;
            end
          end
        end
        SUSPECT: begin
          if (is_fault) begin
            if (f_inc >= F_TH) begin
              state_d     = FAULTED;
              consec_f_d  = 4'd0;
              consec_ok_d = 4'd0;
            end else begin
              consec_f_d = f_inc;
            end
          end else if (is_ok) begin
            state_d     = HEALTHY;
            consec_f_d  = 4'd0;
            consec_ok_d = 4'd0;
          end
        end
        FAULTED: begin
          if (is_ok) begin
            if (RECOVER_THRESH == 1) begin
              state_d     = HEALTHY;
              consec_f_d  = 4'd0;
              consec_ok_d = 4'd0;
            end else begin
              state_d     = RECOVERING;
              consec_ok_d = 4'd1;
            end
          end
        end
        RECOVERING: begin
          if (is_ok) begin
            if (ok_inc >= R_TH) begin
              state_d     = HEALTHY;
              consec_f_d  = 4'd0;
              consec_ok_d = 4'd0;
            end else begin
              consec_ok_d = ok_inc;
            end
          end else if (is_fault) begin
            state_d     = FAULTED;
            consec_f_d  = 4'd0;
            consec_ok_d = 4'd0;
          end
        end
        default: begin
          state_d     = HEALTHY;
          consec_f_d  = 4'd0;
          consec_ok_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HEALTHY;
      consec_f_q  <= 4'd0;
      consec_ok_q <= 4'd0;
    end else if (clear) begin
      state_q     <= HEALTHY;
      consec_f_q  <= 4'd0;
      consec_ok_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      consec_f_q  <= consec_f_d;
      consec_ok_q <= consec_ok_d;
    end
  end

  // Classification outputs and the lifetime counter share the FSM's edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_valid <= 1'b0;
      class_code  <= CLS_NEUTRAL;
      fault_count <= '0;
    end else if (clear) begin
      class_valid <= 1'b0;
      class_code  <= CLS_NEUTRAL;
      fault_count <= '0;
    end else begin
      class_valid <= sample_valid;
      if (sample_valid) class_code <= cls;
      if (sample_valid && is_fault && (fault_count != CNT_MAX))
        fault_count <= fault_count + 1'b1;
    end
  end

  assign state = state_q;
  assign alarm = state_q[1];

endmodule
